pcie_dma_state: RTL

PCIE_DMA_STATE -- requirements
Module: pcie_dma_state

---
 rtl/pcie_dma_state.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pcie_dma_state.sv
// PCIe DMA transfer-state tracker: follows RX request TLPs and TX completions,
// reports the current phase, counts finished reads/writes, flags read timeouts
// and latches the completer bus/device/function.
module pcie_dma_state #(
  parameter int unsigned timeout_cycles = 1024,
  parameter int unsigned cnt_width      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  input  logic                 i_req_ready,
  input  logic                 i_req_sop,
  input  logic                 i_req_last,
  input  logic [1:0]           i_req_type,
  input  logic                 i_cpl_valid,
  input  logic                 i_cpl_ready,
  input  logic                 i_cpl_last,
  input  logic                 i_cfg_valid,
  input  logic [15:0]          i_cfg_bdf,
  input  logic                 i_clr_err,
  output logic [3:0]           o_dma_state,
  output logic [15:0]          o_pcie_completer_id,
  output logic                 o_busy,
  output logic [cnt_width-1:0] o_rd_cnt,
  output logic [cnt_width-1:0] o_wr_cnt
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(timeout_cycles - 1);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_DATA = 4'd1,
    ST_RD_HDR  = 4'd2,
    ST_RD_WAIT = 4'd3,
    ST_RD_CPL  = 4'd4,
    ST_ERR     = 4'd15
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [15:0]           r_completer_id;
  logic                  r_busy;
  logic [cnt_width-1:0]  r_rd_cnt;
  logic [cnt_width-1:0]  r_wr_cnt;
  logic                  w_req_beat;
  logic                  w_cpl_beat;
  logic                  w_wr_inc;
  logic                  w_rd_inc;

  // A beat is a transfer only when both valid and ready are high.
  assign w_req_beat = i_req_valid & i_req_ready;
  assign w_cpl_beat = i_cpl_valid & i_cpl_ready;

  // Next-state and counter-increment decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_inc    = 1'b0;
    w_rd_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_beat && i_req_sop) begin
          if (i_req_type == 2'd0) begin
            w_state_nxt = i_req_last ? ST_RD_WAIT : ST_RD_HDR;
          end else if (i_req_type == 2'd1) begin
            if (i_req_last) w_wr_inc = 1'b1;
            else            w_state_nxt = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (w_req_beat && i_req_last) begin
          w_state_nxt = ST_IDLE;
          w_wr_inc    = 1'b1;
        end
      end
      ST_RD_HDR: begin
        if (w_req_beat && i_req_last) w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // A completion arriving on the limit cycle beats the timeout.
        if (w_cpl_beat) begin
          if (i_cpl_last) begin
            w_state_nxt = ST_IDLE;
            w_rd_inc    = 1'b1;
          end else begin
            w_state_nxt = ST_RD_CPL;
          end
        end else if (r_wait_cnt == WAIT_LIMIT) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_RD_CPL: begin
        if (w_cpl_beat && i_cpl_last) begin
          w_state_nxt = ST_IDLE;
          w_rd_inc    = 1'b1;
        end
      end
      ST_ERR: begin
        if (i_clr_err) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered busy flag derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ERR);
    end
  end

  // Read-completion wait counter; held at zero outside RD_WAIT so entry starts clean.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ST_RD_WAIT)) begin
      r_wait_cnt <= '0;
    end else if (!w_cpl_beat) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Completed-transaction counters, free-running modulo 2^cnt_width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_inc) r_rd_cnt <= r_rd_cnt + cnt_width'(1);
      if (w_wr_inc) r_wr_cnt <= r_wr_cnt + cnt_width'(1);
    end
  end

  // Completer ID capture from the core's config strobe, independent of state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_completer_id <= '0;
    end else if (i_cfg_valid) begin
      r_completer_id <= i_cfg_bdf;
    end
  end

  assign o_dma_state         = r_state;
  assign o_busy              = r_busy;
  assign o_pcie_completer_id = r_completer_id;
  assign o_rd_cnt            = r_rd_cnt;
  assign o_wr_cnt            = r_wr_cnt;

endmodule
